// File: rtl/video_pkg.sv
// Shared types for the video serializer path: display modes and shift-register width.
package video_pkg;

   typedef enum logic [1:0] {
      TEXT  = 2'd0,
      LORES = 2'd1,
      HIRES = 2'd2,
      DBL   = 2'd3
   } vmode_e;

   localparam int SR_W = 14;

   // Lo-res nibbles on odd byte columns start two dots further round the colour cycle.
   function automatic logic [3:0] rot2(input logic [3:0] n);
      return {n[1:0], n[3:2]};
   endfunction

endpackage

// File: rtl/video_pixel_shifter_flash.sv
// Flash phase generator: counts vbl rising edges and toggles flash every FLASH_FRAMES of them.
module flash_counter #(
   parameter int FLASH_FRAMES = 16
) (
   input  logic Clock_14Mhz,
   input  logic Reset,
   input  logic vbl,
   output logic flash
);

   localparam int CW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

   logic          vbl_q;
   logic [CW-1:0] cnt;
   logic          rise;

   assign rise = vbl & ~vbl_q;

   always_ff @(posedge Clock_14Mhz) begin
      if (Reset) begin
         vbl_q <= 1'b0;
         cnt   <= '0;
         flash <= 1'b0;
      end else begin
         vbl_q <= vbl;
         if (rise) begin
            if (cnt == CW'(FLASH_FRAMES - 1)) begin
               cnt   <= '0;
               flash <= ~flash;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/video_pixel_shifter.sv
// Serializes fetched display bytes into video_data for text, lo-res, hi-res and double modes,
// and owns the gfx/text mode pipeline and the flash phase.
module video_pixel_shifter
   import video_pkg::*;
#(
   parameter int PIX_PER_BYTE = 7,
   parameter int MODE_DELAY   = 3,
   parameter int FLASH_FRAMES = 16,
   parameter int DBL_EN       = 1
) (
   input  logic                    Clock_14Mhz,
   input  logic                    Reset,
   input  logic                    pix_en,
   input  logic                    row_tick,
   input  logic                    ld_byte,
   input  logic [7:0]              byte_in,
   input  logic [7:0]              aux_in,
   input  logic [PIX_PER_BYTE-1:0] glyph_in,
   input  logic                    text_mode,
   input  logic                    hires_mode,
   input  logic                    mix_mode,
   input  logic                    dbl_mode,
   input  logic                    vmix,
   input  logic                    lores_hi,
   input  logic                    h_odd,
   input  logic                    blank,
   input  logic                    vbl,
   output logic                    video_data,
   output logic                    color_line,
   output logic                    HIRES,
   output logic                    flash
);

   logic [MODE_DELAY-1:0] pipe;
   logic [MODE_DELAY-1:0] pipe_nxt;
   logic                  gfx;
   logic                  eff_gfx;
   logic                  hires_q;

   vmode_e                mode_sel;
   vmode_e                mode_q;
   logic                  blank_q;
   logic                  b7_q;
   logic                  invert_q;

   logic [SR_W-1:0]       sr;
   logic [SR_W-1:0]       sr_load;
   logic [SR_W-1:0]       sr_shift;
   logic [SR_W-1:0]       sr_nxt;
   logic [3:0]            nib;
   logic                  hold;
   logic                  pix;
   logic                  video_nxt;

   logic                  unused;
   assign unused = aux_in[7];

   flash_counter #(
      .FLASH_FRAMES(FLASH_FRAMES)
   ) u_flash (
      .Clock_14Mhz(Clock_14Mhz),
      .Reset      (Reset),
      .vbl        (vbl),
      .flash      (flash)
   );

   assign color_line = pipe[0];
   assign HIRES      = hires_q;
   assign eff_gfx    = pipe[MODE_DELAY-1];

   always_comb begin
      gfx         = ~((vmix & mix_mode) | text_mode);
      pipe_nxt    = '0;
      pipe_nxt[0] = gfx;
      for (int i = 1; i < MODE_DELAY; i++) begin
         pipe_nxt[i] = pipe[i-1];
      end
   end

   always_comb begin
      mode_sel = video_pkg::LORES;
      if (!eff_gfx)
         mode_sel = video_pkg::TEXT;
      else if (dbl_mode && (DBL_EN != 0))
         mode_sel = video_pkg::DBL;
      else if (hires_mode)
         mode_sel = video_pkg::HIRES;
   end

   always_comb begin
      nib = lores_hi ? byte_in[7:4] : byte_in[3:0];
      if (h_odd)
         nib = rot2(nib);

      sr_load = '0;
      case (mode_sel)
         video_pkg::TEXT:  sr_load[PIX_PER_BYTE-1:0] = glyph_in;
         video_pkg::HIRES: sr_load[PIX_PER_BYTE-1:0] = byte_in[PIX_PER_BYTE-1:0];
         video_pkg::LORES: sr_load[3:0] = nib;
         video_pkg::DBL:   sr_load = {byte_in[6:0], aux_in[6:0]};
         default:          sr_load = '0;
      endcase

      // Text and hi-res run at 7 MHz; lo-res and double run every 14 MHz cycle.
      sr_shift = sr;
      case (mode_q)
         video_pkg::TEXT,
         video_pkg::HIRES: if (pix_en) sr_shift = sr >> 1;
         video_pkg::LORES: sr_shift = {sr[SR_W-1:4], sr[0], sr[3:1]};
         video_pkg::DBL:   sr_shift = sr >> 1;
         default:          sr_shift = sr;
      endcase

      sr_nxt = ld_byte ? sr_load : sr_shift;
   end

   always_comb begin
      pix = sr[0];
      if (mode_q == video_pkg::TEXT)
         pix = sr[0] ^ invert_q;
      else if ((mode_q == video_pkg::HIRES) && b7_q)
         pix = hold;
      video_nxt = blank_q ? 1'b0 : pix;
   end

   always_ff @(posedge Clock_14Mhz) begin
      if (Reset) begin
         pipe       <= '0;
         hires_q    <= 1'b0;
         mode_q     <= video_pkg::TEXT;
         blank_q    <= 1'b0;
         b7_q       <= 1'b0;
         invert_q   <= 1'b0;
         sr         <= '0;
         hold       <= 1'b0;
         video_data <= 1'b0;
      end else begin
         sr         <= sr_nxt;
         hold       <= sr[0];
         video_data <= video_nxt;
         if (ld_byte) begin
            mode_q   <= mode_sel;
            blank_q  <= blank;
            b7_q     <= byte_in[7];
            invert_q <= ~(byte_in[7] | (byte_in[6] & flash));
         end
         if (row_tick) begin
            pipe    <= pipe_nxt;
            hires_q <= hires_mode & pipe_nxt[MODE_DELAY-1];
         end
      end
   end

endmodule

// File: tb/tb_video_pixel_shifter.sv
// Directed bench for video_pixel_shifter: reset, text/flash, blank, mode pipe, hires delay,
// lo-res rotation, double mode and mid-line reset.
module tb_video_pixel_shifter;

   logic       Clock_14Mhz = 1'b0;
   logic       Reset = 1'b1;
   logic       pix_en = 1'b0;
   logic       row_tick = 1'b0;
   logic       ld_byte = 1'b0;
   logic [7:0] byte_in = '0;
   logic [7:0] aux_in = '0;
   logic [6:0] glyph_in = '0;
   logic       text_mode = 1'b1;
   logic       hires_mode = 1'b0;
   logic       mix_mode = 1'b0;
   logic       dbl_mode = 1'b0;
   logic       vmix = 1'b0;
   logic       lores_hi = 1'b0;
   logic       h_odd = 1'b0;
   logic       blank = 1'b0;
   logic       vbl = 1'b0;
   logic       video_data;
   logic       color_line;
   logic       HIRES;
   logic       flash;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 Clock_14Mhz = ~Clock_14Mhz;

   video_pixel_shifter dut (
      .Clock_14Mhz(Clock_14Mhz),
      .Reset      (Reset),
      .pix_en     (pix_en),
      .row_tick   (row_tick),
      .ld_byte    (ld_byte),
      .byte_in    (byte_in),
      .aux_in     (aux_in),
      .glyph_in   (glyph_in),
      .text_mode  (text_mode),
      .hires_mode (hires_mode),
      .mix_mode   (mix_mode),
      .dbl_mode   (dbl_mode),
      .vmix       (vmix),
      .lores_hi   (lores_hi),
      .h_odd      (h_odd),
      .blank      (blank),
      .vbl        (vbl),
      .video_data (video_data),
      .color_line (color_line),
      .HIRES      (HIRES),
      .flash      (flash)
   );

   // One 14 MHz cycle; pix_en alternates so it is high on every other edge.
   task automatic step();
      @(posedge Clock_14Mhz);
      #1;
      pix_en = ~pix_en;
   endtask

   task automatic load(input logic [7:0] b, input logic [7:0] a, input logic [6:0] g,
                       input logic hi, input logic odd, input logic blk);
      if (!pix_en) step();
      byte_in  = b;
      aux_in   = a;
      glyph_in = g;
      lores_hi = hi;
      h_odd    = odd;
      blank    = blk;
      ld_byte  = 1'b1;
      step();
      ld_byte  = 1'b0;
      blank    = 1'b0;
   endtask

   task automatic tick_row();
      row_tick = 1'b1;
      step();
      row_tick = 1'b0;
   endtask

   task automatic vbl_pulse();
      vbl = 1'b1;
      step();
      vbl = 1'b0;
      step();
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ld_byte    = 1'($urandom_range(0, 1));
         row_tick   = 1'($urandom_range(0, 1));
         byte_in    = 8'($urandom_range(0, 255));
         aux_in     = 8'($urandom_range(0, 255));
         glyph_in   = 7'($urandom_range(0, 127));
         text_mode  = 1'($urandom_range(0, 1));
         hires_mode = 1'($urandom_range(0, 1));
         vbl        = 1'($urandom_range(0, 1));
         step();
         n_checks++;
         if ({video_data, color_line, HIRES, flash} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_hold cyc=%0d got vd/cl/hr/fl=%b%b%b%b want 0000",
                     i, video_data, color_line, HIRES, flash);
         end
      end
      ld_byte = 0; row_tick = 0; byte_in = 0; aux_in = 0; glyph_in = 0;
      text_mode = 1; hires_mode = 0; vbl = 0; pix_en = 0;
      Reset = 1'b0;
      step();
      n_checks++;
      if ({video_data, color_line, HIRES, flash} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_release got vd/cl/hr/fl=%b%b%b%b want 0000",
                  video_data, color_line, HIRES, flash);
      end
   endtask

   task automatic test_text();
      logic [6:0] g;
      logic [7:0] bytes [2];
      logic       inv   [2];
      logic       exp;
      g = 7'b1010101;
      bytes[0] = 8'h80; inv[0] = 1'b0;
      bytes[1] = 8'h00; inv[1] = 1'b1;
      text_mode = 1'b1;
      for (int v = 0; v < 2; v++) begin
         load(bytes[v], 8'h00, g, 1'b0, 1'b0, 1'b0);
         for (int k = 0; k < 14; k++) begin
            step();
            exp = g[k/2] ^ inv[v];
            n_checks++;
            if (video_data !== exp) begin
               n_fail++;
               $display("FAIL text byte=%h k=%0d got %b want %b", bytes[v], k, video_data, exp);
            end
         end
      end
   endtask

   task automatic test_flash();
      logic [6:0] g;
      logic       inv [3];
      logic       exp;
      g = 7'b0110011;
      inv[0] = 1'b1; inv[1] = 1'b0; inv[2] = 1'b1;
      for (int r = 0; r < 3; r++) begin
         load(8'h40, 8'h00, g, 1'b0, 1'b0, 1'b0);
         for (int k = 0; k < 14; k++) begin
            step();
            exp = g[k/2] ^ inv[r];
            n_checks++;
            if (video_data !== exp) begin
               n_fail++;
               $display("FAIL flash_text round=%0d k=%0d got %b want %b", r, k, video_data, exp);
            end
         end
         if (r < 2) begin
            for (int p = 0; p < 15; p++) vbl_pulse();
            n_checks++;
            if (flash !== r[0]) begin
               n_fail++;
               $display("FAIL flash_15_rises round=%0d got %b want %b", r, flash, r[0]);
            end
            vbl_pulse();
            n_checks++;
            if (flash !== ~r[0]) begin
               n_fail++;
               $display("FAIL flash_16_rises round=%0d got %b want %b", r, flash, ~r[0]);
            end
         end
      end
   endtask

   task automatic test_blank();
      load(8'h80, 8'h00, 7'h7F, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 14; k++) begin
         step();
         n_checks++;
         if (video_data !== 1'b0) begin
            n_fail++;
            $display("FAIL blank k=%0d got %b want 0", k, video_data);
         end
      end
   endtask

   task automatic test_mix();
      logic [2:0] hr_up;
      logic [2:0] hr_dn;
      hr_up = 3'b100;
      hr_dn = 3'b011;
      text_mode = 1'b0; mix_mode = 1'b1; vmix = 1'b0; hires_mode = 1'b1;
      for (int t = 0; t < 3; t++) begin
         tick_row();
         n_checks++;
         if ({color_line, HIRES} !== {1'b1, hr_up[t]}) begin
            n_fail++;
            $display("FAIL mix_rise tick=%0d got cl/hr=%b%b want 1%b", t, color_line, HIRES, hr_up[t]);
         end
      end
      vmix = 1'b1;
      step();
      n_checks++;
      if (color_line !== 1'b1) begin
         n_fail++;
         $display("FAIL mix_no_tick got cl=%b want 1", color_line);
      end
      for (int t = 0; t < 3; t++) begin
         tick_row();
         n_checks++;
         if ({color_line, HIRES} !== {1'b0, hr_dn[t]}) begin
            n_fail++;
            $display("FAIL mix_fall tick=%0d got cl/hr=%b%b want 0%b", t, color_line, HIRES, hr_dn[t]);
         end
      end
      vmix = 1'b0;
      for (int t = 0; t < 3; t++) tick_row();
      n_checks++;
      if ({color_line, HIRES} !== 2'b11) begin
         n_fail++;
         $display("FAIL mix_restore got cl/hr=%b%b want 11", color_line, HIRES);
      end
   endtask

   task automatic test_hires();
      logic [13:0] exp_plain;
      logic [13:0] exp_dly;
      exp_plain = 14'b00000000000011;
      exp_dly   = 14'b00000000000110;
      hires_mode = 1'b1;
      load(8'h01, 8'h00, 7'h00, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 14; k++) begin
         step();
         n_checks++;
         if (video_data !== exp_plain[k]) begin
            n_fail++;
            $display("FAIL hires_plain k=%0d got %b want %b", k, video_data, exp_plain[k]);
         end
      end
      load(8'h81, 8'h00, 7'h00, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 14; k++) begin
         step();
         n_checks++;
         if (video_data !== exp_dly[k]) begin
            n_fail++;
            $display("FAIL hires_delay k=%0d got %b want %b", k, video_data, exp_dly[k]);
         end
      end
   endtask

   task automatic test_lores();
      logic [7:0] bytes [4];
      logic       his   [4];
      logic       odds  [4];
      logic [3:0] pat   [4];
      hires_mode = 1'b0;
      bytes[0] = 8'hA5; his[0] = 1'b0; odds[0] = 1'b1; pat[0] = 4'b0101;
      bytes[1] = 8'hA5; his[1] = 1'b1; odds[1] = 1'b0; pat[1] = 4'b1010;
      bytes[2] = 8'h03; his[2] = 1'b0; odds[2] = 1'b0; pat[2] = 4'b0011;
      bytes[3] = 8'h03; his[3] = 1'b0; odds[3] = 1'b1; pat[3] = 4'b1100;
      for (int v = 0; v < 4; v++) begin
         load(bytes[v], 8'h00, 7'h00, his[v], odds[v], 1'b0);
         for (int k = 0; k < 8; k++) begin
            step();
            n_checks++;
            if (video_data !== pat[v][k%4]) begin
               n_fail++;
               $display("FAIL lores v=%0d k=%0d got %b want %b", v, k, video_data, pat[v][k%4]);
            end
         end
      end
   endtask

   task automatic test_dbl();
      logic [13:0] exp;
      exp = 14'b00000001111111;
      dbl_mode = 1'b1;
      load(8'h00, 8'h7F, 7'h00, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 14; k++) begin
         step();
         n_checks++;
         if (video_data !== exp[k]) begin
            n_fail++;
            $display("FAIL dbl k=%0d got %b want %b", k, video_data, exp[k]);
         end
      end
   endtask

   task automatic test_midline_reset();
      load(8'h00, 8'h7F, 7'h00, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) step();
      n_checks++;
      if ({video_data, color_line, HIRES} !== 3'b111) begin
         n_fail++;
         $display("FAIL midreset_pre got vd/cl/hr=%b%b%b want 111", video_data, color_line, HIRES);
      end
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      n_checks++;
      if ({video_data, color_line, HIRES, flash} !== 4'b0000) begin
         n_fail++;
         $display("FAIL midreset_clear got vd/cl/hr/fl=%b%b%b%b want 0000",
                  video_data, color_line, HIRES, flash);
      end
      for (int k = 0; k < 4; k++) begin
         step();
         n_checks++;
         if (video_data !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_idle k=%0d got %b want 0", k, video_data);
         end
      end
      dbl_mode = 1'b0; text_mode = 1'b1;
      load(8'h80, 8'h00, 7'h7F, 1'b0, 1'b0, 1'b0);
      step();
      n_checks++;
      if (video_data !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_resume got %b want 1", video_data);
      end
   endtask

   initial begin
      test_reset();
      test_text();
      test_flash();
      test_blank();
      test_mix();
      test_hires();
      test_lores();
      test_dbl();
      test_midline_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
